// File: rtl/alu_seq.sv
// Sequential ALU for the execute stage: single-cycle logic/arithmetic ops,
// iterative SHL and shift-add MUL, results held until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             mem_update
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LUI = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE   = (SHW+1)'(1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;    // SHL value, or MUL upper partial product
    logic [WIDTH-1:0] lo_q, lo_d;        // MUL multiplier / lower product half
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] result_q;
    logic             flag_n_q, flag_z_q, flag_c_q, flag_v_q;

    logic             commit;
    logic [WIDTH-1:0] res_new;
    logic             c_new, v_new;

    logic [WIDTH:0]   sum_ext, dif_ext;
    logic [WIDTH-1:0] lui_val;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    logic [WIDTH-1:0] shl_next;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [SHW-1:0]   shl_amt;

    // Single-cycle datapath, evaluated directly on the request operands
    always_comb begin
        sum_ext = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_in};
        dif_ext = {1'b0, in_a} - {1'b0, in_b};
        lui_val = {in_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif_ext[WIDTH-1:0];
                alu_c   = dif_ext[WIDTH];
                alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                          (dif_ext[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_LUI:  alu_res = lui_val;
            default: alu_res = in_a;
        endcase
    end

    // Iterative step logic: SHL shifts one bit, MUL adds then shifts right
    always_comb begin
        shl_next = {work_q[WIDTH-2:0], 1'b0};
        mul_sum  = {1'b0, work_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_hi   = mul_sum[WIDTH:1];
        mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
        shl_amt  = in_b[SHW-1:0];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        commit  = 1'b0;
        res_new = result_q;
        c_new   = flag_c_q;
        v_new   = flag_v_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    if (op == OP_MUL) begin
                        mcand_d = in_a;
                        lo_d    = in_b;
                        work_d  = '0;
                        cnt_d   = MUL_STEPS;
                        state_d = S_BUSY;
                    end else if (op == OP_SHL && shl_amt != '0) begin
                        work_d  = in_a;
                        cnt_d   = {1'b0, shl_amt};
                        state_d = S_BUSY;
                    end else begin
                        commit  = 1'b1;
                        res_new = alu_res;
                        c_new   = alu_c;
                        v_new   = alu_v;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    work_d = mul_hi;
                    lo_d   = mul_lo;
                    if (cnt_q == CNT_ONE) begin
                        commit  = 1'b1;
                        res_new = mul_lo;
                        c_new   = |mul_hi;
                        v_new   = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    work_d = shl_next;
                    if (cnt_q == CNT_ONE) begin
                        commit  = 1'b1;
                        res_new = shl_next;
                        c_new   = work_q[WIDTH-1];
                        v_new   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            work_q   <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            if (commit) begin
                result_q <= res_new;
                flag_n_q <= res_new[WIDTH-1];
                flag_z_q <= (res_new == '0);
                flag_c_q <= c_new;
                flag_v_q <= v_new;
            end
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign mem_update = out_valid && out_ready;
    assign result     = result_q;
    assign flag_n     = flag_n_q;
    assign flag_z     = flag_z_q;
    assign flag_c     = flag_c_q;
    assign flag_v     = flag_v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues hand-computed expectations,
// a monitor checks each presented result, its latency and the handoff strobe.
module tb_alu_seq;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, LUI = 3'b101, SHL = 3'b110, MUL = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [15:0] in_a = 16'h0, in_b = 16'h0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        mem_update;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in_a(in_a), .in_b(in_b), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .mem_update(mem_update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        n, z, c, v;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 0;
    bit   drop_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples 2ns after the falling edge, once the driver has settled
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (drop_chk) begin
            chk("valid_drop", {31'd0, out_valid}, 32'd0);
            drop_chk = 0;
        end
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb[0];
                if (!seen) begin
                    chk("latency", cyc - e.acc + 1, e.lat);
                    seen = 1;
                end
                if (out_ready) begin
                    chk("result", {16'd0, result}, {16'd0, e.res});
                    chk("flags_nzcv", {28'd0, flag_n, flag_z, flag_c, flag_v},
                        {28'd0, e.n, e.z, e.c, e.v});
                    chk("mem_update", {31'd0, mem_update}, 32'd1);
                    $display("txn: result=0x%04h nzcv=%b%b%b%b latency_ok cycle=%0d",
                             result, flag_n, flag_z, flag_c, flag_v, cyc);
                    sb.pop_front();
                    seen = 0;
                    drop_chk = 1;
                end else begin
                    chk("hold_result", {16'd0, result}, {16'd0, e.res});
                    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("hold_mem_update", {31'd0, mem_update}, 32'd0);
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] r,
                         input logic n, input logic z, input logic c, input logic v,
                         input int lat, input bit push);
        exp_t e;
        wait_ready();
        op = o; in_a = a; in_b = b; carry_in = ci; in_valid = 1'b1;
        if (push) begin
            e.res = r; e.n = n; e.z = z; e.c = c; e.v = v; e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom); in_a = 16'($urandom); in_b = 16'($urandom); carry_in = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mem_update", {31'd0, mem_update}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        //     op    a        b        ci    result   n  z  c  v  lat
        issue(ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1, 0, 0, 1, 1, 1);
        issue(ADD,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 0, 1, 1, 0, 1, 1);
        issue(SUB,  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1, 0, 1, 0, 1, 1);
        issue(SUB,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 0, 0, 1, 1, 1);
        issue(LUI,  16'h5555, 16'h12AB, 1'b1, 16'hAB00, 1, 0, 0, 0, 1, 1);
        issue(XOR_, 16'hF0F0, 16'hF0F0, 1'b0, 16'h0000, 0, 1, 0, 0, 1, 1);
        issue(AND_, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 0, 0, 0, 0, 1, 1);
        issue(OR_,  16'h1200, 16'h0034, 1'b0, 16'h1234, 0, 0, 0, 0, 1, 1);
        issue(SHL,  16'h8001, 16'h0001, 1'b0, 16'h0002, 0, 0, 1, 0, 2, 1);
        issue(SHL,  16'h0001, 16'h0004, 1'b0, 16'h0010, 0, 0, 0, 0, 5, 1);
        issue(SHL,  16'h8001, 16'h0000, 1'b1, 16'h8001, 1, 0, 0, 0, 1, 1);
        issue(SHL,  16'h0003, 16'hFFFF, 1'b0, 16'h8000, 1, 0, 1, 0, 16, 1);
        issue(MUL,  16'h0100, 16'h0101, 1'b0, 16'h0100, 0, 0, 1, 0, 17, 1);
        drain();

        // Hold the result with out_ready low for 5 cycles, then release
        out_ready = 1'b0;
        issue(MUL,  16'h00FF, 16'h00FF, 1'b0, 16'hFE01, 1, 0, 0, 0, 17, 1);
        begin
            int t = 0;
            while (!out_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("hold_reached_valid", {31'd0, out_valid}, 32'd1);
        end
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset asserted 8 cycles into a MUL discards it
        issue(MUL, 16'h1234, 16'h5678, 1'b0, 16'h0, 0, 0, 0, 0, 17, 0);
        repeat (7) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", {16'd0, result}, 32'd0);
        chk("midrst_flags", {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_mem_update", {31'd0, mem_update}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        issue(ADD, 16'h0001, 16'h0002, 1'b1, 16'h0004, 0, 0, 0, 0, 1, 1);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU that replaces the single-cycle add/load-upper datapath in the CPU execute stage. It accepts one operation at a time over a valid/ready handshake and computes single-cycle logic/arithmetic ops, an iterative left shift and an iterative shift-add multiply. It holds results and NZCV flags until the consumer takes them, and issues a one-cycle memory/register update strobe on each accepted result.

## Interface
- WIDTH, 16: datapath width. Must be even and ≥ 4.
- SHW, $clog2(WIDTH): width of the shift-amount field (derived; do not override).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LUI, 110 SHL, 111 MUL.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B (LUI immediate, SHL amount in in_b[SHW-1:0]).
- carry_in  in  1  carry into ADD; ignored by other ops.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flag_n, flag_z, flag_c, flag_v  out  1 each  negative, zero, carry/borrow, signed overflow.
- mem_update  out  1  one-cycle strobe, high in the cycle where out_valid && out_ready.

## Operation
- States: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). Accept = in_valid && in_ready at a rising edge; op and operands are captured into internal registers.
- IDLE, accept ADD/SUB/AND/OR/XOR/LUI: result and flags are computed and registered on the accepting edge -> DONE.
- IDLE, accept SHL with amount 0: result = in_a -> DONE. Amount k > 0: -> BUSY, shift the working register left by 1 per cycle, k cycles, then -> DONE.
- IDLE, accept MUL: -> BUSY, one multiplier bit per cycle (LSB first, add-then-shift), WIDTH cycles, then -> DONE.
- DONE: hold result and flags stable. When out_ready is high: mem_update = 1 and the FSM goes to IDLE on that edge.
- Arithmetic, all results truncated to WIDTH:
  - ADD: {C, R} = A + B + carry_in; V = signed overflow.
  - SUB: R = A − B; C = 1 when A < B unsigned (borrow); V = signed overflow.
  - AND/OR/XOR: C = V = 0.
  - LUI: R = {in_b[WIDTH/2-1:0], WIDTH/2 zeros}; C = V = 0.
  - SHL: C = last bit shifted out (0 for amount 0); V = 0.
  - MUL: R = low WIDTH bits of the unsigned 2·WIDTH-bit product; C = 1 when the high half is nonzero; V = 0.
  - All ops: N = R[WIDTH-1]; Z = (R == 0).
- in_valid is ignored outside IDLE; operands may change freely after accept.
- Reset, asserted at any time including mid-BUSY: state = IDLE; result = 0; all flags = 0; out_valid = 0; mem_update = 0; in_ready = 1 after deassertion. Any in-flight operation is discarded.

## Timing
- Latency (accepting edge to out_valid high):
  - Single-cycle ops and SHL amount 0: out_valid rises right after the accepting edge (1 cycle).
  - SHL amount k: k + 1 cycles.
  - MUL: WIDTH + 1 cycles.
- out_valid = (state == DONE); it remains high with stable outputs for as long as out_ready is low.
- Minimum issue interval is 2 cycles (accept, then hand off); there is no overlap of operations.
- mem_update is combinational: out_valid && out_ready. It is never high for more than one cycle per result.

## Test plan
- ADD 0x7FFF + 0x0001, carry_in = 0 -> result 0x8000; N=1, Z=0, C=0, V=1; out_valid 1 cycle after accept. ADD 0xFFFF + 0x0000, carry_in = 1 -> 0x0000; Z=1, C=1.
- SUB 0x0003 − 0x0005 -> 0xFFFE; N=1, C=1, V=0. SUB 0x8000 − 0x0001 -> 0x7FFF; V=1.
- LUI in_b = 0x12AB -> 0xAB00, C=V=0. XOR 0xF0F0 ^ 0xF0F0 -> 0x0000, Z=1.
- SHL in_a = 0x8001, in_b = 1 -> 0x0002, C=1, after 2 cycles. in_b = 4 on 0x0001 -> 0x0010 after 5 cycles. in_b = 0 -> 0x8001 after 1 cycle.
- MUL 0x0100 × 0x0101 -> 0x0100, C=1, out_valid after 17 cycles. MUL 0x00FF × 0x00FF -> 0xFE01, C=0. Hold out_ready low 5 cycles: outputs stable, in_ready=0, mem_update=0; then raise out_ready -> exactly one mem_update pulse.
- Assert rst_n low mid-MUL at cycle 8 -> result 0, flags 0, out_valid 0 immediately. After release, in_ready=1, and a new ADD completes correctly.
